// File: rtl/instruction_cache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
package instruction_cache_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_READ = 2'd1,
      UPDATE   = 2'd2
   } state_e;

   localparam int TAG_LSB    = 7;
   localparam int INDEX_LSB  = 4;
   localparam int WORD_LSB   = 2;
   localparam int BLOCK_BITS = 128;

endpackage

// File: rtl/instruction_cache_word_select.sv
// Picks one 32-bit word out of a 128-bit block; word 0 lives in the low bits.
module instruction_cache_word_select
   import instruction_cache_pkg::*;
(
   input  logic [BLOCK_BITS-1:0] block_i,
   input  logic [1:0]            word_sel_i,
   output logic [31:0]           word_o
);

   always_comb begin
      word_o = block_i[31:0];
      case (word_sel_i)
         2'b00: word_o = block_i[31:0];
         2'b01: word_o = block_i[63:32];
         2'b10: word_o = block_i[95:64];
         2'b11: word_o = block_i[127:96];
         default: word_o = block_i[31:0];
      endcase
   end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache: same-cycle hits, block refill from instruction memory on a miss.
//
// state    | meaning
// IDLE     | serving hits; a miss latches the block address and starts a fill
// MEM_READ | mem_read high, waiting for the memory to drop busywait
// UPDATE   | mem_read low for one cycle while the returned block is written
module instruction_cache
   import instruction_cache_pkg::*;
#(
   parameter int INDEX_BITS = 3,
   parameter int TAG_BITS   = 28 - INDEX_BITS,
   parameter int BLOCK_BITS = instruction_cache_pkg::BLOCK_BITS
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  cpu_read,
   input  logic [31:0]           cpu_address,
   output logic [31:0]           cpu_instruction,
   output logic                  cpu_busywait,
   output logic                  mem_read,
   output logic [27:0]           mem_address,
   input  logic [BLOCK_BITS-1:0] mem_readinst,
   input  logic                  mem_busywait
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [BLOCK_BITS-1:0] data_q  [LINES];
   logic [TAG_BITS-1:0]   tag_q   [LINES];
   logic [LINES-1:0]      valid_q;

   state_e      state_q;
   logic [27:0] miss_addr_q;
   logic        mem_read_q;
   logic        first_q;

   logic [INDEX_BITS-1:0] idx;
   logic [TAG_BITS-1:0]   tag_in;
   logic [INDEX_BITS-1:0] miss_idx;
   logic [TAG_BITS-1:0]   miss_tag;
   logic [1:0]            word_sel;
   logic [31:0]           sel_word;
   logic                  hit;
   logic                  unused_byte_bits;

   assign idx              = cpu_address[INDEX_LSB +: INDEX_BITS];
   assign tag_in           = cpu_address[31 -: TAG_BITS];
   assign word_sel         = cpu_address[WORD_LSB +: 2];
   assign miss_idx         = miss_addr_q[INDEX_BITS-1:0];
   assign miss_tag         = miss_addr_q[27 -: TAG_BITS];
   assign unused_byte_bits = ^cpu_address[1:0];

   assign hit = cpu_read & valid_q[idx] & (tag_q[idx] == tag_in);

   instruction_cache_word_select u_word_select (
      .block_i    (data_q[idx]),
      .word_sel_i (word_sel),
      .word_o     (sel_word)
   );

   assign cpu_instruction = hit ? sel_word : 32'h0;
   // Gated by reset so the stall drops immediately on an asynchronous reset.
   assign cpu_busywait    = reset_n & ((state_q == IDLE) ? (cpu_read & ~hit) : 1'b1);
   assign mem_read        = mem_read_q;
   assign mem_address     = miss_addr_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         miss_addr_q <= '0;
         mem_read_q  <= 1'b0;
         first_q     <= 1'b0;
         valid_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cpu_read && !hit) begin
                  miss_addr_q <= cpu_address[31:4];
                  mem_read_q  <= 1'b1;
                  first_q     <= 1'b1;
                  state_q     <= MEM_READ;
               end
            end
            MEM_READ: begin
               // The first edge may still see a stale low busywait from the memory.
               if (first_q) begin
                  first_q <= 1'b0;
               end else if (!mem_busywait) begin
                  mem_read_q <= 1'b0;
                  state_q    <= UPDATE;
               end
            end
            UPDATE: begin
               valid_q[miss_idx] <= 1'b1;
               state_q           <= IDLE;
            end
            default: begin
               mem_read_q <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (state_q == UPDATE) begin
         data_q[miss_idx] <= mem_readinst;
         tag_q[miss_idx]  <= miss_tag;
      end
   end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a fixed-latency block memory model.
module tb_instruction_cache;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         cpu_read = 1'b0;
   logic [31:0]  cpu_address = 32'h0;
   logic [31:0]  cpu_instruction;
   logic         cpu_busywait;
   logic         mem_read;
   logic [27:0]  mem_address;
   logic [127:0] mem_readinst;
   logic         mem_busywait;

   int n_pass = 0;
   int n_total = 0;

   always #5 clock = ~clock;

   instruction_cache dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .cpu_read        (cpu_read),
      .cpu_address     (cpu_address),
      .cpu_instruction (cpu_instruction),
      .cpu_busywait    (cpu_busywait),
      .mem_read        (mem_read),
      .mem_address     (mem_address),
      .mem_readinst    (mem_readinst),
      .mem_busywait    (mem_busywait)
   );

   // Memory contents: block 0 is a fixed program fragment, other blocks encode their address.
   function automatic logic [127:0] mem_blk(input logic [27:0] baddr);
      logic [127:0] b;
      if (baddr == 28'h0) begin
         b = {32'h0000F613, 32'h00100113, 32'h00000000, 32'h8F108093};
      end else begin
         for (int w = 0; w < 4; w++)
            b[w*32 +: 32] = 32'hC000_0000 | (32'(baddr) << 8) | 32'(w);
      end
      return b;
   endfunction

   localparam int LAT = 3;
   int           mem_cnt = 0;
   logic         mem_done = 1'b0;
   logic [127:0] mem_rdata = '0;

   always @(posedge clock) begin
      if (!mem_read) begin
         mem_cnt  <= 0;
         mem_done <= 1'b0;
      end else if (!mem_done) begin
         if (mem_cnt == LAT - 1) begin
            mem_done  <= 1'b1;
            mem_rdata <= mem_blk(mem_address);
         end else begin
            mem_cnt <= mem_cnt + 1;
         end
      end
   end

   assign mem_busywait = mem_read & ~mem_done;
   assign mem_readinst = mem_rdata;

   // Records, for each rising mem_read, how many sampled cycles it had been low.
   int   low_run = 0;
   logic prev_mem_read = 1'b0;
   int   rise_low_q[$];
   logic [27:0] rise_addr_q[$];

   always @(negedge clock) begin
      if (mem_read && !prev_mem_read) begin
         rise_low_q.push_back(low_run);
         rise_addr_q.push_back(mem_address);
         low_run = 0;
      end else if (!mem_read) begin
         low_run++;
      end
      prev_mem_read = mem_read;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic fetch_miss(input string nm, input logic [31:0] addr, input logic [31:0] exp_instr);
      int k;
      int kr;
      logic [27:0] ra;
      @(negedge clock);
      cpu_address = addr;
      cpu_read    = 1'b1;
      #1;
      chk({nm, "_busy_on_miss"}, 32'(cpu_busywait), 32'd1);
      chk({nm, "_instr_zero_on_miss"}, cpu_instruction, 32'h0);
      k  = 0;
      kr = -1;
      ra = '0;
      while (cpu_busywait && k < 50) begin
         @(negedge clock);
         k++;
         if (mem_read && kr < 0) begin
            kr = k;
            ra = mem_address;
         end
      end
      chk({nm, "_mem_read_delay"}, 32'(kr), 32'd1);
      chk({nm, "_mem_address"}, {4'h0, ra}, {4'h0, addr[31:4]});
      chk({nm, "_stall_cycles"}, 32'(k), 32'd6);
      chk({nm, "_instr"}, cpu_instruction, exp_instr);
      chk({nm, "_busy_after"}, 32'(cpu_busywait), 32'd0);
   endtask

   typedef struct {
      logic        rd;
      logic [31:0] addr;
      logic [31:0] instr;
      logic        busy;
   } vec_t;

   vec_t vecs[11];

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         @(negedge clock);
         cpu_read    = vecs[i].rd;
         cpu_address = vecs[i].addr;
         #1;
         chk($sformatf("vec%0d_instr", i), cpu_instruction, vecs[i].instr);
         chk($sformatf("vec%0d_busy", i), 32'(cpu_busywait), 32'(vecs[i].busy));
         chk($sformatf("vec%0d_no_mem_read", i), 32'(mem_read), 32'd0);
      end
   endtask

   initial begin
      int k;
      vecs[0]  = '{1'b1, 32'h0000_0000, 32'h8F108093, 1'b0};
      vecs[1]  = '{1'b1, 32'h0000_0004, 32'h00000000, 1'b0};
      vecs[2]  = '{1'b1, 32'h0000_0008, 32'h00100113, 1'b0};
      vecs[3]  = '{1'b1, 32'h0000_000F, 32'h0000F613, 1'b0};
      vecs[4]  = '{1'b0, 32'h0000_0000, 32'h00000000, 1'b0};
      vecs[5]  = '{1'b1, 32'h0000_0010, 32'hC0000100, 1'b0};
      vecs[6]  = '{1'b1, 32'h0000_0014, 32'hC0000101, 1'b0};
      vecs[7]  = '{1'b1, 32'h0000_0028, 32'hC0000202, 1'b0};
      vecs[8]  = '{1'b1, 32'h0000_002C, 32'hC0000203, 1'b0};
      vecs[9]  = '{1'b1, 32'h0000_000C, 32'h0000F613, 1'b0};
      vecs[10] = '{1'b1, 32'h0000_0090, 32'h00000000, 1'b1};

      // Reset values, with a request pending while reset is held.
      cpu_read = 1'b1;
      #2;
      chk("rst_busywait", 32'(cpu_busywait), 32'd0);
      chk("rst_mem_read", 32'(mem_read), 32'd0);
      chk("rst_mem_address", {4'h0, mem_address}, 32'h0);
      chk("rst_instr", cpu_instruction, 32'h0);
      cpu_read = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      fetch_miss("cold0", 32'h0000_0000, 32'h8F108093);
      run_vecs(0, 4);

      fetch_miss("b2b_10", 32'h0000_0010, 32'hC0000100);
      fetch_miss("b2b_20", 32'h0000_0020, 32'hC0000200);
      chk("b2b_two_pulses", 32'(rise_low_q.size()), 32'd3);
      if (rise_low_q.size() == 3) begin
         chk("b2b_gap_low", 32'(rise_low_q[2] >= 1), 32'd1);
         chk("b2b_pulse1_addr", {4'h0, rise_addr_q[1]}, 32'h1);
         chk("b2b_pulse2_addr", {4'h0, rise_addr_q[2]}, 32'h2);
      end
      run_vecs(5, 9);

      // Line 0 was block 0; block 8 evicts it, row 10 in the table stays a miss.
      fetch_miss("conflict80", 32'h0000_0080, 32'hC0000800);
      fetch_miss("refetch0", 32'h0000_0000, 32'h8F108093);
      @(negedge clock);
      cpu_read    = 1'b1;
      cpu_address = 32'h0000_0084;
      #1;
      chk("evicted80_busy", 32'(cpu_busywait), 32'd1);
      cpu_read = 1'b0;
      // Let that miss finish before moving on.
      k = 0;
      while (cpu_busywait && k < 50) begin
         @(negedge clock);
         k++;
      end
      chk("evicted80_done", 32'(k < 50), 32'd1);
      run_vecs(10, 10);
      cpu_read = 1'b0;
      k = 0;
      while (cpu_busywait && k < 50) begin
         @(negedge clock);
         k++;
      end
      chk("miss90_done", 32'(k < 50), 32'd1);

      // cpu_read dropped mid-fill: the line still installs.
      @(negedge clock);
      cpu_address = 32'h0000_0030;
      cpu_read    = 1'b1;
      @(negedge clock);
      chk("drop_mem_read_up", 32'(mem_read), 32'd1);
      cpu_read = 1'b0;
      #1;
      chk("drop_busy_in_memread", 32'(cpu_busywait), 32'd1);
      k = 0;
      while (mem_read && k < 50) begin
         @(negedge clock);
         k++;
      end
      chk("drop_fill_ends", 32'(k < 50), 32'd1);
      @(negedge clock);
      @(negedge clock);
      cpu_read = 1'b1;
      #1;
      chk("drop_hit_busy", 32'(cpu_busywait), 32'd0);
      chk("drop_hit_instr", cpu_instruction, 32'hC0000300);
      @(negedge clock);
      chk("drop_hit_no_mem_read", 32'(mem_read), 32'd0);

      // Asynchronous reset in the middle of a fill.
      cpu_address = 32'h0000_0040;
      k = 0;
      while (!mem_read && k < 20) begin
         @(negedge clock);
         k++;
      end
      chk("rstmid_in_memread", 32'(mem_read), 32'd1);
      @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      chk("rstmid_mem_read", 32'(mem_read), 32'd0);
      chk("rstmid_busywait", 32'(cpu_busywait), 32'd0);
      cpu_read = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      fetch_miss("after_rst0", 32'h0000_0000, 32'h8F108093);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, %0d/%0d", n_pass, n_total);
      $fatal(1);
   end

endmodule
